// File: rtl/sound_arbiter.sv
// Fixed-priority, preemptive arbiter that shares one square-wave speaker between
// the wall-bounce, paddle-hit and ball-miss sound requesters.
module sound_arbiter #(
    parameter int HP0  = 28409,
    parameter int HP1  = 14204,
    parameter int HP2  = 56818,
    parameter int DUR0 = 4,
    parameter int DUR1 = 4,
    parameter int DUR2 = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [2:0] req,
    output logic       speaker,
    output logic       busy,
    output logic [2:0] active
);
    typedef enum logic {IDLE, PLAY} state_t;

    state_t      state;
    logic [2:0]  pending;
    logic [16:0] tone_cnt;
    logic [5:0]  frames_left;
    logic [1:0]  cur;

    logic [2:0]  cand;
    logic [2:0]  cur_oh;
    logic [2:0]  higher_mask;
    logic [2:0]  rest;
    logic [2:0]  grant_src;
    logic [2:0]  grant_oh;
    logic [1:0]  grant_idx;
    logic        tone_end;
    logic        do_grant;

    function automatic logic [16:0] hp_m1(input logic [1:0] g);
        case (g)
            2'd2:    return 17'(HP2 - 1);
            2'd1:    return 17'(HP1 - 1);
            default: return 17'(HP0 - 1);
        endcase
    endfunction

    function automatic logic [5:0] dur_of(input logic [1:0] g);
        case (g)
            2'd2:    return 6'(DUR2);
            2'd1:    return 6'(DUR1);
            default: return 6'(DUR0);
        endcase
    endfunction

    function automatic logic [1:0] top_idx(input logic [2:0] c);
        if (c[2])      return 2'd2;
        else if (c[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path infers a latch.
        do_grant  = 1'b0;
        cand      = pending | req;
        cur_oh    = 3'b001 << cur;
        rest      = cand & ~cur_oh;
        grant_src = cand;
        tone_end  = frame_tick && (frames_left == 6'd1);
        case (cur)
            2'd0:    higher_mask = 3'b110;
            2'd1:    higher_mask = 3'b100;
            default: higher_mask = 3'b000;
        endcase

        // Preemption outranks end-of-tone; the preempted source is dropped via rest.
        if (state == IDLE) begin
            do_grant = |cand;
        end else if (|(cand & higher_mask)) begin
            do_grant  = 1'b1;
            grant_src = rest;
        end else if (tone_end) begin
            do_grant  = |rest;
            grant_src = rest;
        end
        grant_idx = top_idx(grant_src);
        grant_oh  = 3'b001 << grant_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 3'b000;
            tone_cnt    <= 17'd0;
            frames_left <= 6'd0;
            cur         <= 2'd0;
            speaker     <= 1'b0;
            busy        <= 1'b0;
            active      <= 3'b000;
        end else if (!enable) begin
            state       <= IDLE;
            pending     <= 3'b000;
            tone_cnt    <= 17'd0;
            frames_left <= 6'd0;
            cur         <= 2'd0;
            speaker     <= 1'b0;
            busy        <= 1'b0;
            active      <= 3'b000;
        end else if (do_grant) begin
            state       <= PLAY;
            pending     <= grant_src & ~grant_oh;
            tone_cnt    <= 17'd0;
            frames_left <= dur_of(grant_idx);
            cur         <= grant_idx;
            speaker     <= 1'b0;
            busy        <= 1'b1;
            active      <= grant_oh;
        end else if (state == PLAY) begin
            if (tone_end) begin
                state       <= IDLE;
                pending     <= 3'b000;
                tone_cnt    <= 17'd0;
                frames_left <= 6'd0;
                cur         <= 2'd0;
                speaker     <= 1'b0;
                busy        <= 1'b0;
                active      <= 3'b000;
            end else begin
                pending <= rest;
                // A retrigger reloads the duration but keeps the tone phase running.
                if (|(req & cur_oh))
                    frames_left <= dur_of(cur);
                else if (frame_tick)
                    frames_left <= frames_left - 6'd1;
                if (tone_cnt == hp_m1(cur)) begin
                    tone_cnt <= 17'd0;
                    speaker  <= ~speaker;
                end else begin
                    tone_cnt <= tone_cnt + 17'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        assert (DUR0 >= 1 && DUR0 <= 63 && DUR1 >= 1 && DUR1 <= 63 && DUR2 >= 1 && DUR2 <= 63)
            else $error("sound_arbiter: DUR parameter outside 1..63");
        assert (HP0 >= 2 && HP0 < 131072 && HP1 >= 2 && HP1 < 131072 && HP2 >= 2 && HP2 < 131072)
            else $error("sound_arbiter: HP parameter outside 2..131071");
    end

endmodule
